// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM encoding, AHB constants,
// accelerator register map and the layer-config field layout used by cnn_accel.
package cnn_layer_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_FRAME, S_W_WH, S_W_DELAY, S_W_BASE, S_W_CFG, S_W_START1,
    S_W_START0, S_POLL_GAP, S_POLL_RD, S_NEXT, S_FIN, S_ERR
  } seq_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [31:0] CNN_ACCEL_BASE         = 32'h4000_0000;
  localparam logic [31:0] CNN_ACCEL_FRAME_SIZE   = CNN_ACCEL_BASE + 32'h00;
  localparam logic [31:0] CNN_ACCEL_WIDTH_HEIGHT = CNN_ACCEL_BASE + 32'h04;
  localparam logic [31:0] CNN_ACCEL_DELAY_PARAMS = CNN_ACCEL_BASE + 32'h08;
  localparam logic [31:0] CNN_ACCEL_BASE_ADDRESS = CNN_ACCEL_BASE + 32'h0C;
  localparam logic [31:0] CNN_ACCEL_LAYER_CONFIG = CNN_ACCEL_BASE + 32'h10;
  localparam logic [31:0] CNN_ACCEL_LAYER_START  = CNN_ACCEL_BASE + 32'h14;
  localparam logic [31:0] CNN_ACCEL_LAYER_DONE   = CNN_ACCEL_BASE + 32'h18;

  localparam int CFG_FIRST_B = 0;
  localparam int CFG_LAST_B  = 1;
  localparam int CFG_CONV_B  = 2;
  localparam int CFG_LAST2_B = 3;
  localparam int CFG_IDX_B   = 4;
  localparam int CFG_BIAS_B  = 8;
  localparam int CFG_ACT_B   = 13;

  // desc is the stored cfg descriptor {act_shift[8:6], bias_shift[5:1], is_conv3x3[0]}
  function automatic logic [31:0] pack_layer_cfg(input logic [8:0] desc, input logic [3:0] idx,
                                                 input logic is_first, input logic is_last);
    logic [31:0] w;
    w = '0;
    w[CFG_FIRST_B]      = is_first;
    w[CFG_LAST_B]       = is_last;
    w[CFG_CONV_B]       = desc[0];
    w[CFG_LAST2_B]      = is_last;
    w[CFG_IDX_B +: 4]   = idx;
    w[CFG_BIAS_B +: 5]  = desc[5:1];
    w[CFG_ACT_B +: 3]   = desc[8:6];
    return w;
  endfunction

endpackage

// File: rtl/cnn_seq_ahb_if.sv
// Single-transfer AHB-Lite master engine: one NONSEQ address phase, then IDLE
// through the data phase; ack fires on the completing data-phase cycle.
module cnn_seq_ahb_if
  import cnn_layer_sequencer_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic        o_err,
  output logic [31:0] o_rdata,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [1:0]  HTRANS
);

  typedef enum logic [1:0] {E_IDLE, E_ADDR, E_DATA} eng_state_e;

  eng_state_e r_state;
  logic       w_resp_err;

  // An ERROR response terminates the data phase even on its first (HREADY low) cycle
  assign w_resp_err = (HRESP == HRESP_ERROR);
  assign o_ack      = (r_state == E_DATA) && (HREADY || w_resp_err);
  assign o_err      = o_ack && w_resp_err;
  assign o_rdata    = HRDATA;
  assign HSIZE      = HSIZE_WORD;
  assign HBURST     = HBURST_SINGLE;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= E_IDLE;
      HTRANS  <= HTRANS_IDLE;
      HADDR   <= '0;
      HWDATA  <= '0;
      HWRITE  <= 1'b0;
    end else begin
      case (r_state)
        E_IDLE: if (i_req) begin
          HTRANS  <= HTRANS_NONSEQ;
          HADDR   <= i_addr;
          HWRITE  <= i_we;
          HWDATA  <= i_wdata;
          r_state <= E_ADDR;
        end
        E_ADDR: if (HREADY) begin
          HTRANS  <= HTRANS_IDLE;
          r_state <= E_DATA;
        end
        E_DATA: if (o_ack) r_state <= E_IDLE;
        default: r_state <= E_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// AHB master that programs the CNN accelerator frame registers, then runs each
// layer from the descriptor table and polls for layer completion.
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int N_LAYER      = 3,
  parameter int POLL_GAP     = 16,
  parameter int POLL_TIMEOUT = 1 << 20
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        i_start,
  input  logic [3:0]  i_n_layer,
  input  logic [24:0] i_frame_size,
  input  logic [11:0] i_width,
  input  logic [11:0] i_height,
  input  logic [11:0] i_start_up_delay,
  input  logic [11:0] i_hsync_delay,
  input  logic        i_desc_we,
  input  logic [3:0]  i_desc_idx,
  input  logic        i_desc_sel,
  input  logic [31:0] i_desc_data,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [1:0]  HTRANS,
  output logic        o_busy,
  output logic [3:0]  o_layer_idx,
  output logic        o_done,
  output logic        o_err
);

  localparam int IW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  seq_state_e    r_state;
  logic [8:0]    r_desc_cfg  [2**IW];
  logic [31:0]   r_desc_base [2**IW];
  logic [3:0]    r_n_layer;
  logic [24:0]   r_frame_size;
  logic [11:0]   r_width, r_height, r_sud, r_hsd;
  logic [GW-1:0] r_gap;
  logic [PW-1:0] r_polls;

  logic          w_req, w_we, w_ack, w_herr, w_is_last, w_unused_rdata;
  logic [31:0]   w_addr, w_wdata, w_rdata;
  logic [IW-1:0] w_tbl_idx, w_wr_idx;
  seq_state_e    w_wr_next;

  assign w_tbl_idx      = o_layer_idx[IW-1:0];
  assign w_wr_idx       = i_desc_idx[IW-1:0];
  assign w_is_last      = (o_layer_idx == r_n_layer - 4'd1);
  assign w_unused_rdata = ^w_rdata[31:1];

  always_comb begin
    w_req     = 1'b1;
    w_we      = 1'b1;
    w_addr    = '0;
    w_wdata   = '0;
    w_wr_next = S_IDLE;
    case (r_state)
      S_W_FRAME:  begin w_addr = CNN_ACCEL_FRAME_SIZE;   w_wdata = {7'b0, r_frame_size}; w_wr_next = S_W_WH; end
      S_W_WH:     begin w_addr = CNN_ACCEL_WIDTH_HEIGHT; w_wdata = {4'b0, r_height, 4'b0, r_width}; w_wr_next = S_W_DELAY; end
      S_W_DELAY:  begin w_addr = CNN_ACCEL_DELAY_PARAMS; w_wdata = {8'b0, r_hsd, r_sud}; w_wr_next = S_W_BASE; end
      S_W_BASE:   begin w_addr = CNN_ACCEL_BASE_ADDRESS; w_wdata = r_desc_base[w_tbl_idx]; w_wr_next = S_W_CFG; end
      S_W_CFG:    begin
        w_addr    = CNN_ACCEL_LAYER_CONFIG;
        w_wdata   = pack_layer_cfg(r_desc_cfg[w_tbl_idx], o_layer_idx, o_layer_idx == 4'd0, w_is_last);
        w_wr_next = S_W_START1;
      end
      S_W_START1: begin w_addr = CNN_ACCEL_LAYER_START;  w_wdata = 32'd1; w_wr_next = S_W_START0; end
      S_W_START0: begin w_addr = CNN_ACCEL_LAYER_START;  w_wdata = 32'd0; w_wr_next = S_POLL_GAP; end
      S_POLL_RD:  begin w_addr = CNN_ACCEL_LAYER_DONE;   w_we = 1'b0; end
      default:    w_req = 1'b0;
    endcase
  end

  cnn_seq_ahb_if u_ahb (
    .HCLK(HCLK), .HRESET(HRESET),
    .i_req(w_req), .i_we(w_we), .i_addr(w_addr), .i_wdata(w_wdata),
    .o_ack(w_ack), .o_err(w_herr), .o_rdata(w_rdata),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < 2**IW; i++) begin
        r_desc_cfg[i]  <= '0;
        r_desc_base[i] <= '0;
      end
    end else if (i_desc_we && !o_busy && ({1'b0, i_desc_idx} < 5'(N_LAYER))) begin
      if (i_desc_sel) r_desc_base[w_wr_idx] <= i_desc_data;
      else            r_desc_cfg[w_wr_idx]  <= i_desc_data[8:0];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      o_busy       <= 1'b0;
      o_layer_idx  <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      r_n_layer    <= '0;
      r_frame_size <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_sud        <= '0;
      r_hsd        <= '0;
      r_gap        <= '0;
      r_polls      <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          o_err        <= 1'b0;
          o_layer_idx  <= '0;
          r_n_layer    <= i_n_layer;
          r_frame_size <= i_frame_size;
          r_width      <= i_width;
          r_height     <= i_height;
          r_sud        <= i_start_up_delay;
          r_hsd        <= i_hsync_delay;
          if (i_n_layer == 4'd0)                      o_done  <= 1'b1;
          else if ({1'b0, i_n_layer} > 5'(N_LAYER))   r_state <= S_ERR;
          else begin
            r_state <= S_W_FRAME;
            o_busy  <= 1'b1;
          end
        end
        S_W_FRAME, S_W_WH, S_W_DELAY, S_W_BASE, S_W_CFG, S_W_START1, S_W_START0:
          if (w_ack) begin
            r_state <= w_herr ? S_ERR : w_wr_next;
            r_gap   <= '0;
            r_polls <= '0;
          end
        S_POLL_GAP:
          if (r_gap == GW'(POLL_GAP - 1)) r_state <= S_POLL_RD;
          else                            r_gap   <= r_gap + 1'b1;
        S_POLL_RD: if (w_ack) begin
          if (w_herr)                               r_state <= S_ERR;
          else if (w_rdata[0])                      r_state <= S_NEXT;
          else if (r_polls == PW'(POLL_TIMEOUT - 1)) r_state <= S_ERR;
          else begin
            r_polls <= r_polls + 1'b1;
            r_gap   <= '0;
            r_state <= S_POLL_GAP;
          end
        end
        S_NEXT:
          if (w_is_last) r_state <= S_FIN;
          else begin
            o_layer_idx <= o_layer_idx + 4'd1;
            r_state     <= S_W_BASE;
          end
        S_FIN: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          o_err   <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: reactive AHB slave model with a write scoreboard.
module tb_cnn_layer_sequencer;

  localparam int N_LAYER = 3, POLL_GAP = 4, POLL_TIMEOUT = 8, DONE_DLY = 50;
  localparam logic [31:0] A_FRAME = 32'h4000_0000, A_WH = 32'h4000_0004, A_DLY = 32'h4000_0008,
                          A_BASE = 32'h4000_000C, A_CFG = 32'h4000_0010, A_START = 32'h4000_0014,
                          A_DONE = 32'h4000_0018;
  localparam logic [24:0] FS  = 25'h1_2345;
  localparam logic [11:0] WD  = 12'd640, HT = 12'd480, SUD = 12'h00A, HSD = 12'h015;

  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic        i_start = 1'b0, i_desc_we = 1'b0, i_desc_sel = 1'b0;
  logic [3:0]  i_n_layer = '0, i_desc_idx = '0;
  logic [31:0] i_desc_data = '0;
  logic [31:0] HRDATA = '0;
  logic [1:0]  HRESP = 2'b00;
  logic        HREADY = 1'b1;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE, o_busy, o_done, o_err;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [3:0]  o_layer_idx;

  always #5 HCLK = ~HCLK;

  cnn_layer_sequencer #(.N_LAYER(N_LAYER), .POLL_GAP(POLL_GAP), .POLL_TIMEOUT(POLL_TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start), .i_n_layer(i_n_layer),
    .i_frame_size(FS), .i_width(WD), .i_height(HT), .i_start_up_delay(SUD), .i_hsync_delay(HSD),
    .i_desc_we(i_desc_we), .i_desc_idx(i_desc_idx), .i_desc_sel(i_desc_sel), .i_desc_data(i_desc_data),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .o_busy(o_busy), .o_layer_idx(o_layer_idx), .o_done(o_done), .o_err(o_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [8:0]  sh_cfg  [N_LAYER];
  logic [31:0] sh_base [N_LAYER];
  logic [63:0] exp_q [$];

  function automatic logic [31:0] exp_cfg(input int i, input int n);
    logic last;
    last = (i == n - 1);
    return {16'b0, sh_cfg[i][8:6], sh_cfg[i][5:1], 4'(i), last, sh_cfg[i][0], last, 1'(i == 0)};
  endfunction

  task automatic push_run(input int n, input int max_w);
    logic [63:0] w [$];
    w.push_back({A_FRAME, 7'b0, FS});
    w.push_back({A_WH, 4'b0, HT, 4'b0, WD});
    w.push_back({A_DLY, 8'b0, HSD, SUD});
    for (int i = 0; i < n; i++) begin
      w.push_back({A_BASE, sh_base[i]});
      w.push_back({A_CFG, exp_cfg(i, n)});
      w.push_back({A_START, 32'd1});
      w.push_back({A_START, 32'd0});
    end
    for (int i = 0; i < w.size() && i < max_w; i++) exp_q.push_back(w[i]);
  endtask

  // slave model state
  int          cyc = 0, wait_left = 0, ws = 0, start_cyc = 0, err_cfg_n = 0;
  int          n_reads = 0, n_nonseq = 0, n_extra = 0, n_bad = 0, n_done = 0, n_cfg_wr = 0;
  bit          done_en = 1'b1;
  logic        dp = 1'b0, dp_wr = 1'b0, last_nonseq = 1'b0, last_hready = 1'b1, last_wr = 1'b0;
  logic [31:0] dp_addr = '0, dp_wd0 = '0, last_addr = '0, first_cfg = '0;
  logic        rst_q = 1'b1;

  always @(posedge HCLK) rst_q <= HRESET;

  always @(negedge HCLK) begin
    cyc++;
    if (o_done) n_done++;
    if (rst_q) dp = 1'b0;
    else begin
      if (dp && last_hready) dp = 1'b0;
      if (last_nonseq && last_hready) begin
        dp = 1'b1; dp_wr = last_wr; dp_addr = last_addr; wait_left = ws; dp_wd0 = HWDATA;
      end
    end
    HRESP = 2'b00; HREADY = 1'b1; HRDATA = '0;
    if (dp) begin
      if (HTRANS != 2'b00) n_bad++;
      if (wait_left > 0) begin
        HREADY = 1'b0;
        wait_left--;
      end else if (dp_wr) begin
        if (HWDATA !== dp_wd0) n_bad++;
        if (dp_addr == A_START && HWDATA == 32'd1) start_cyc = cyc;
        if (dp_addr == A_CFG) begin
          n_cfg_wr++;
          if (n_cfg_wr == 1) first_cfg = HWDATA;
          if (n_cfg_wr == err_cfg_n) HRESP = 2'b01;
        end
        if (exp_q.size() > 0) chk("wr_seq", {dp_addr, HWDATA}, exp_q.pop_front());
        else n_extra++;
      end else if (dp_addr == A_DONE) begin
        n_reads++;
        HRDATA = {31'b0, done_en && (cyc - start_cyc >= DONE_DLY)};
      end else n_bad++;
    end
    if (HTRANS == 2'b10) begin
      n_nonseq++;
      if (HSIZE != 3'b010 || HBURST != 3'b000) n_bad++;
    end
    last_nonseq = (HTRANS == 2'b10);
    last_addr   = HADDR;
    last_wr     = HWRITE;
    last_hready = HREADY;
  end

  task automatic desc_write(input int idx, input logic sel, input logic [31:0] d);
    @(negedge HCLK);
    i_desc_we = 1'b1; i_desc_idx = 4'(idx); i_desc_sel = sel; i_desc_data = d;
    @(negedge HCLK);
    i_desc_we = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    @(negedge HCLK);
    i_n_layer = 4'(n); i_start = 1'b1;
    @(negedge HCLK);
    i_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int d0, k;
    d0 = n_done;
    for (k = 0; k < bound; k++) begin
      @(negedge HCLK);
      if (n_done != d0 || o_err) break;
    end
    chk({tag, "_timeout"}, 64'(k >= bound), 64'd0);
    repeat (4) @(negedge HCLK);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_htrans"}, 64'(HTRANS), 64'd0);
    chk({tag, "_haddr"},  64'(HADDR), 64'd0);
    chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
    chk({tag, "_ctl"},    64'({HWRITE, HSIZE, HBURST}), 64'({1'b0, 3'b010, 3'b000}));
    chk({tag, "_outs"},   64'({o_busy, o_layer_idx, o_done, o_err}), 64'd0);
  endtask

  task automatic clr_cnt();
    n_done = 0; n_reads = 0; n_extra = 0; n_bad = 0; n_cfg_wr = 0;
  endtask

  initial begin
    int nn;
    repeat (3) @(negedge HCLK);
    chk_reset("rst");
    HRESET = 1'b0;

    sh_cfg[0] = {3'd7, 5'd9, 1'b0};  sh_base[0] = 32'h1000_0100;
    sh_cfg[1] = {3'd7, 5'd17, 1'b1}; sh_base[1] = 32'h1010_2200;
    sh_cfg[2] = {3'd7, 5'd17, 1'b1}; sh_base[2] = 32'h1020_4300;
    for (int i = 0; i < N_LAYER; i++) begin
      desc_write(i, 1'b0, {23'b0, sh_cfg[i]});
      desc_write(i, 1'b1, sh_base[i]);
    end

    // three layers, zero wait states
    clr_cnt();
    push_run(3, 99);
    pulse_start(3);
    chk("t1_busy", 64'(o_busy), 64'd1);
    wait_end("t1", 5000);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_cfg0", 64'(first_cfg), 64'h0000_E901);
    chk("t1_done_cnt", 64'(n_done), 64'd1);
    chk("t1_flags", 64'({o_busy, o_err}), 64'd0);
    chk("t1_proto", 64'({n_extra, n_bad}), 64'd0);

    // three wait states; start and descriptor write while busy are ignored
    clr_cnt();
    ws = 3;
    push_run(3, 99);
    pulse_start(3);
    repeat (10) @(negedge HCLK);
    i_start = 1'b1; i_desc_we = 1'b1; i_desc_idx = 4'd0; i_desc_sel = 1'b0; i_desc_data = 32'h1FF;
    @(negedge HCLK);
    i_start = 1'b0; i_desc_we = 1'b0;
    wait_end("t2", 8000);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_done_cnt", 64'(n_done), 64'd1);
    chk("t2_proto", 64'({n_extra, n_bad}), 64'd0);
    ws = 0;

    // ERROR on layer-1 config write
    clr_cnt();
    err_cfg_n = 2;
    push_run(3, 9);
    pulse_start(3);
    wait_end("t3", 5000);
    nn = n_nonseq;
    repeat (20) @(negedge HCLK);
    chk("t3_no_nonseq", 64'(n_nonseq - nn), 64'd0);
    chk("t3_err_busy", 64'({o_err, o_busy}), 64'({1'b1, 1'b0}));
    chk("t3_no_done", 64'(n_done), 64'd0);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_extra", 64'(n_extra), 64'd0);
    err_cfg_n = 0;

    // zero layers: immediate done, error cleared, no bus traffic
    clr_cnt();
    nn = n_nonseq;
    pulse_start(0);
    chk("t4_done", 64'(o_done), 64'd1);
    chk("t4_err_clr", 64'(o_err), 64'd0);
    repeat (5) @(negedge HCLK);
    chk("t4_idle", 64'(n_nonseq - nn), 64'd0);
    chk("t4_done_cnt", 64'(n_done), 64'd1);

    // too many layers: error without transfers
    nn = n_nonseq;
    pulse_start(4);
    repeat (3) @(negedge HCLK);
    chk("t5_err", 64'({o_err, o_busy}), 64'({1'b1, 1'b0}));
    chk("t5_idle", 64'(n_nonseq - nn), 64'd0);

    // done never set: exactly POLL_TIMEOUT reads then error
    clr_cnt();
    done_en = 1'b0;
    push_run(1, 99);
    pulse_start(1);
    wait_end("t6", 3000);
    chk("t6_reads", 64'(n_reads), 64'(POLL_TIMEOUT));
    chk("t6_err", 64'(o_err), 64'd1);
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_no_done", 64'(n_done), 64'd0);
    done_en = 1'b1;

    // reset during layer-1 polling, then rerun with the cleared table
    clr_cnt();
    push_run(3, 99);
    pulse_start(3);
    begin
      int k;
      for (k = 0; k < 3000; k++) begin
        @(negedge HCLK);
        if (o_layer_idx == 4'd1 && HTRANS == 2'b10 && HADDR == A_DONE) break;
      end
      chk("t7_reach_poll", 64'(k >= 3000), 64'd0);
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    chk_reset("t7_rst");
    HRESET = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N_LAYER; i++) begin sh_cfg[i] = '0; sh_base[i] = '0; end
    clr_cnt();
    push_run(1, 99);
    pulse_start(1);
    wait_end("t7", 3000);
    chk("t7_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t7_done_cnt", 64'(n_done), 64'd1);
    chk("t7_err", 64'(o_err), 64'd0);
    chk("t7_proto", 64'({n_extra, n_bad}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

AHB-Lite bus master that programs and runs the CNN accelerator layer by layer, replacing the RISC-V software loop for standalone network execution. It writes the frame-level registers once, then for each layer writes base address, layer config and a start pulse, and polls the layer-done register before advancing. It sits on the accelerator's AHB slave port, in place of the CPU master, and is configured through a local descriptor write port.

## Interface
- N_LAYER, 3: maximum layers held in the descriptor table (1..16)
- POLL_GAP, 16: idle cycles between done-status reads
- POLL_TIMEOUT, 2^20: maximum polls per layer before error
- HCLK in 1: clock
- HRESET in 1: synchronous, active-high reset
- i_start in 1: one-cycle pulse to run the network; ignored while o_busy
- i_n_layer in 4: layers to run
- i_frame_size in 25: frame size
- i_width in 12: frame width
- i_height in 12: frame height
- i_start_up_delay in 12: startup delay
- i_hsync_delay in 12: hsync delay
- i_desc_we in 1: descriptor write strobe; ignored while o_busy
- i_desc_idx in 4: layer index
- i_desc_sel in 1: 0 selects cfg word {act_shift[8:6], bias_shift[5:1], is_conv3x3[0]}; 1 selects base word {param[31:20], weight[19:0]}
- i_desc_data in 32: descriptor data
- HRDATA in 32, HRESP in 2, HREADY in 1: AHB master inputs
- HADDR out 32, HWDATA out 32, HWRITE out 1, HSIZE out 3, HBURST out 3, HTRANS out 2: AHB master outputs
- o_busy out 1: sequence running
- o_layer_idx out 4: current layer
- o_done out 1: one-cycle pulse on completion
- o_err out 1: sticky error; cleared by the next accepted i_start

## Operation
- States: IDLE → W_FRAME → W_WH → W_DELAY → [per layer] W_BASE → W_CFG → W_START1 → W_START0 → POLL_GAP → POLL_RD → (done? NEXT : POLL_GAP) → NEXT → W_BASE | FIN → IDLE. Any → ERR → IDLE.
- Register addresses and data:
  - W_FRAME writes `CNN_ACCEL_FRAME_SIZE` with {7'b0, frame_size}.
  - W_WH writes `CNN_ACCEL_WIDTH_HEIGHT` with {4'b0, height, 4'b0, width}.
  - W_DELAY writes `CNN_ACCEL_DELAY_PARAMS` with {8'b0, hsync_delay, start_up_delay}.
  - W_BASE writes `CNN_ACCEL_BASE_ADDRESS` with the descriptor base word.
  - W_CFG writes `CNN_ACCEL_LAYER_CONFIG` with {16'b0, act_shift, bias_shift, idx, is_last, is_conv3x3, is_last, is_first}, where is_first = (idx==0) and is_last = (idx==i_n_layer-1).
  - W_START1 writes `CNN_ACCEL_LAYER_START` with 1; W_START0 writes it with 0.
  - POLL_RD reads `CNN_ACCEL_LAYER_DONE`; bit0 set means the layer is done.
- Frame parameters and i_n_layer are latched on the accepted i_start.
- i_n_layer==0: o_done pulses and no bus transfer is issued. i_n_layer>N_LAYER: ERR with no transfers.
- ERR conditions: HRESP==ERROR in any data phase (transfer aborts, HTRANS IDLE on the next cycle), or poll count reaching POLL_TIMEOUT. In ERR, o_err is set, o_busy is cleared and no o_done pulse is issued.

## Timing
- Single transfers only: HTRANS NONSEQ (2'b10) for one address-phase cycle, then IDLE until the data phase completes. No pipelining. HSIZE 3'b010, HBURST SINGLE.
- The address phase holds while HREADY is low. In the data phase, HWDATA is valid and held until HREADY is high; HRDATA is sampled on the HREADY-high cycle.
- Each transfer takes a minimum of 2 cycles, plus one IDLE cycle before the next. With zero wait states, W_FRAME starts on the cycle after i_start.
- o_done is asserted in the cycle after FIN; o_busy drops in the same cycle.
- Reset values: HTRANS 2'b00, HADDR 0, HWDATA 0, HWRITE 0, HSIZE 3'b010, HBURST 0, o_busy 0, o_layer_idx 0, o_done 0, o_err 0. The descriptor table is zeroed.
- Reset mid-transfer: HTRANS is IDLE on the cycle after reset is sampled.

## Structure
- Shared package/header: state encoding; HTRANS/HSIZE/HBURST constants (from amba_ahb_h.v); the layer-config field offsets, shared with cnn_accel.
- Sub-module cnn_seq_ahb_if: single-transfer AHB engine. Interface: req/we/addr/wdata → ack/rdata/err.
- The top level holds the FSM, descriptor table, layer counter and poll/gap counters.

## Test plan
- 3 layers as {bias 9/7/0, 17/7/1, 17/7/1}, slave returns done after 50 cycles → write sequence as listed. Layer-0 config = 16'hE900|0x001 per packing with is_first=1. Layer-2 has is_last bits set. o_done pulses once.
- Slave inserts 3 wait states on every transfer → HADDR/HWDATA held stable, same write order, no dropped or duplicated transfer.
- HRESP ERROR on the layer-1 W_CFG data phase → no further NONSEQ, o_err=1, o_busy=0, no o_done. The next i_start clears o_err.
- Done never set, POLL_TIMEOUT=8 → exactly 8 reads, then o_err.
- i_n_layer=0 → o_done the next cycle, HTRANS stays IDLE. i_start and i_desc_we while busy → ignored, table unchanged.
- HRESET asserted during layer-1 polling → all outputs at reset values the next cycle. A fresh i_start reruns from W_FRAME.
